// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan controller: glyph table and segment encodings.
package ssd_pkg;

    // Segment bit positions inside the active-low {Ca,Cb,Cc,Cd,Ce,Cf,Cg} vector
    localparam int unsigned SEG_W = 7;
    localparam int unsigned SEG_A = 6;
    localparam int unsigned SEG_B = 5;
    localparam int unsigned SEG_C = 4;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 2;
    localparam int unsigned SEG_F = 1;
    localparam int unsigned SEG_G = 0;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    // Only the middle bar lit
    localparam logic [SEG_W-1:0] SEG_DASH  = SEG_BLANK & ~(7'(1) << SEG_G);

    // Active-low hex glyphs, entry n is the pattern for nibble n (b and d lowercase)
    localparam logic [15:0][SEG_W-1:0] HEX_GLYPH = {
        7'h38, 7'h30, 7'h42, 7'h31,   // F E d C
        7'h60, 7'h08, 7'h04, 7'h00,   // b A 9 8
        7'h0F, 7'h20, 7'h24, 7'h4C,   // 7 6 5 4
        7'h06, 7'h12, 7'h4F, 7'h01    // 3 2 1 0
    };

    // True when a nibble has no decimal digit representation
    function automatic logic isNonDecimal(input logic [3:0] nibble);
        return nibble > 4'd9;
    endfunction

endpackage

// File: rtl/ssd_glyph_decoder.sv
// Combinational nibble-to-segment decoder; BCD mode replaces A..F with a dash.
module ssd_glyph_decoder
    import ssd_pkg::*;
(
    input  logic [3:0]       nibble,
    input  logic             modeBcd,
    output logic [SEG_W-1:0] glyph_c
);

    // Table lookup with dash override for non-decimal nibbles in BCD mode
    always_comb begin
        glyph_c = HEX_GLYPH[nibble];
        if (modeBcd && isNonDecimal(nibble)) begin
            glyph_c = SEG_DASH;
        end
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multi-digit seven-segment scan controller with double-buffered load,
// leading-zero blanking, per-digit enable/decimal point and PWM brightness.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned PWM_W      = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    mode_bcd,
    input  logic [PWM_W-1:0]        brightness,
    output logic                    load_ack,
    output logic                    frame_done,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [SEG_W-1:0]        ssdOut,
    output logic                    dp
);

    localparam int unsigned IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W    = $clog2(SCAN_DIV);
    localparam int unsigned PWM_LAST = (1 << PWM_W) - 2;

    logic [CNT_W-1:0]                scanCnt;
    logic [IDX_W-1:0]                digitIdx;
    logic [PWM_W-1:0]                pwmCnt;

    logic [NUM_DIGITS-1:0][3:0]      shadowValue;
    logic [NUM_DIGITS-1:0]           shadowDp;
    logic [NUM_DIGITS-1:0]           shadowEn;
    logic [NUM_DIGITS-1:0][3:0]      activeValue;
    logic [NUM_DIGITS-1:0]           activeDp;
    logic [NUM_DIGITS-1:0]           activeEn;
    logic                            pending;

    logic                            slotEnd;
    logic                            frameEnd;
    logic                            pwmOn;
    logic [NUM_DIGITS-1:0]           zeroBlank;
    logic                            upperZero;
    logic                            blank;
    logic [3:0]                      curNibble;
    logic [SEG_W-1:0]                curGlyph;
    logic [NUM_DIGITS-1:0]           anodeNext;
    logic [SEG_W-1:0]                segNext;
    logic                            dpNext;

    assign slotEnd   = (scanCnt == CNT_W'(SCAN_DIV - 1));
    assign frameEnd  = slotEnd && (digitIdx == IDX_W'(NUM_DIGITS - 1));
    assign pwmOn     = (pwmCnt < brightness);
    assign curNibble = activeValue[digitIdx];

    // Prescaler, digit index and free-running PWM counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scanCnt  <= '0;
            digitIdx <= '0;
            pwmCnt   <= '0;
        end else begin
            scanCnt <= slotEnd ? '0 : scanCnt + CNT_W'(1);
            if (slotEnd) begin
                digitIdx <= (digitIdx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digitIdx + IDX_W'(1);
            end
            pwmCnt <= (pwmCnt == PWM_W'(PWM_LAST)) ? '0 : pwmCnt + PWM_W'(1);
        end
    end

    // Shadow capture on load; shadow promoted to active at the frame boundary.
    // A load on the boundary edge keeps pending set so its data waits one more frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadowValue <= '0;
            shadowDp    <= '0;
            shadowEn    <= '0;
            activeValue <= '0;
            activeDp    <= '0;
            activeEn    <= '0;
            pending     <= 1'b0;
        end else begin
            if (frameEnd && pending) begin
                activeValue <= shadowValue;
                activeDp    <= shadowDp;
                activeEn    <= shadowEn;
            end
            if (load) begin
                shadowValue <= value_in;
                shadowDp    <= dp_in;
                shadowEn    <= digit_en;
                pending     <= 1'b1;
            end else if (frameEnd) begin
                pending <= 1'b0;
            end
        end
    end

    // Leading-zero mask: digit i>0 blanks when it and every higher nibble are zero
    always_comb begin
        upperZero = 1'b1;
        zeroBlank = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            upperZero    = upperZero && (activeValue[i] == 4'd0);
            zeroBlank[i] = (i != 0) && upperZero;
        end
    end

    ssd_glyph_decoder uGlyph (
        .nibble  (curNibble),
        .modeBcd (mode_bcd),
        .glyph_c (curGlyph)
    );

    // Next pin values for the currently scanned digit
    always_comb begin
        anodeNext = '1;
        segNext   = SEG_BLANK;
        dpNext    = 1'b1;
        blank     = !activeEn[digitIdx] || !pwmOn || (mode_bcd && zeroBlank[digitIdx]);
        if (!blank) begin
            anodeNext[digitIdx] = 1'b0;
            segNext             = curGlyph;
            dpNext              = ~activeDp[digitIdx];
        end
    end

    // Registered pin drive and handshake pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            anode      <= '1;
            ssdOut     <= SEG_BLANK;
            dp         <= 1'b1;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            anode      <= anodeNext;
            ssdOut     <= segNext;
            dp         <= dpNext;
            load_ack   <= load;
            frame_done <= frameEnd;
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Randomised bench for ssd_scan_ctrl (4 digits, 4-cycle slots) against a timeline model.
module tb_ssd_scan_ctrl;

    localparam int ND   = 4;
    localparam int SD   = 4;
    localparam int PW   = 4;
    localparam int FRM  = ND * SD;
    localparam int PPER = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          load;
    logic [15:0]   value_in;
    logic [3:0]    dp_in;
    logic [3:0]    digit_en;
    logic          mode_bcd;
    logic [3:0]    brightness;
    logic          load_ack;
    logic          frame_done;
    logic [3:0]    anode;
    logic [6:0]    ssdOut;
    logic          dp;

    typedef struct {
        int          at;
        logic [15:0] v;
        logic [3:0]  d;
        logic [3:0]  en;
    } loadRec_t;

    loadRec_t loadLog[$];
    int checks = 0;
    int errors = 0;
    int e      = 0;

    ssd_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .PWM_W(PW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .mode_bcd   (mode_bcd),
        .brightness (brightness),
        .load_ack   (load_ack),
        .frame_done (frame_done),
        .anode      (anode),
        .ssdOut     (ssdOut),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%h exp=%h", tag, e, got, exp);
        end
    endtask

    // Active-low glyph as seen on the display
    function automatic logic [6:0] glyphOf(input int n, input logic bcd);
        if (bcd && n > 9) return 7'b1111110;
        case (n)
            0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;  3: return 7'b0000110;
            4: return 7'b1001100;  5: return 7'b0100100;  6: return 7'b0100000;  7: return 7'b0001111;
            8: return 7'b0000000;  9: return 7'b0000100; 10: return 7'b0001000; 11: return 7'b1100000;
           12: return 7'b0110001; 13: return 7'b1000010; 14: return 7'b0110000; default: return 7'b0111000;
        endcase
    endfunction

    task automatic checkReset();
        checkVal("rst_anode", 16'(anode), 16'hF);
        checkVal("rst_seg", 16'(ssdOut), 16'h7F);
        checkVal("rst_dp", 16'(dp), 16'h1);
        checkVal("rst_ack", 16'(load_ack), 16'h0);
        checkVal("rst_fd", 16'(frame_done), 16'h0);
    endtask

    // Outputs just after edge e follow the scan position and displayed data before that edge.
    // Displayed data: the last load strictly before the latest frame boundary edge preceding e.
    task automatic checkEdge();
        int idx, pwm, bnd, nib;
        logic [15:0] av, expAnode;
        logic [3:0]  ad, aen;
        logic        isBlank;
        logic [6:0]  expSeg;
        logic        expDp;
        idx = (e / SD) % ND;
        pwm = e % PPER;
        bnd = (e / FRM) * FRM - 1;
        av = '0; ad = '0; aen = '0;
        for (int k = loadLog.size() - 1; k >= 0; k--) begin
            if (loadLog[k].at < bnd) begin
                av = loadLog[k].v; ad = loadLog[k].d; aen = loadLog[k].en;
                break;
            end
        end
        nib = int'((av >> (4 * idx)) & 16'hF);
        isBlank = !aen[idx] || !(pwm < int'(brightness)) ||
                  (mode_bcd && idx > 0 && (av >> (4 * idx)) == 16'd0);
        if (isBlank) begin
            expAnode = 16'hF; expSeg = 7'h7F; expDp = 1'b1;
        end else begin
            expAnode = 16'hF & ~(16'd1 << idx);
            expSeg   = glyphOf(nib, mode_bcd);
            expDp    = ~ad[idx];
        end
        checkVal("anode", 16'(anode), expAnode);
        checkVal("seg", 16'(ssdOut), 16'(expSeg));
        checkVal("dp", 16'(dp), 16'(expDp));
        checkVal("load_ack", 16'(load_ack), 16'(load));
        checkVal("frame_done", 16'(frame_done), 16'((e % FRM) == FRM - 1));
    endtask

    task automatic doLoad(input logic [15:0] v, input logic [3:0] d, input logic [3:0] en);
        load = 1'b1; value_in = v; dp_in = d; digit_en = en;
        loadLog.push_back('{e, v, d, en});
    endtask

    task automatic runCycle(input bit directed);
        int k;
        logic [15:0] v;
        load = 1'b0;
        if (directed) begin
            case (e)
                0:   begin mode_bcd = 1'b0; brightness = 4'd15; doLoad(16'h12AF, 4'h0, 4'hF); end
                64:  begin mode_bcd = 1'b1; doLoad(16'h0047, 4'h0, 4'hF); end
                100: doLoad(16'h0000, 4'h0, 4'hF);
                140: doLoad(16'h00C3, 4'h0, 4'hF);
                150: doLoad(16'h1111, 4'h0, 4'hF);
                155: doLoad(16'h2222, 4'h0, 4'hF);
                175: doLoad(16'h3333, 4'h0, 4'hF);
                192: brightness = 4'd0;
                208: begin brightness = 4'd7; mode_bcd = 1'b0; doLoad(16'h5678, 4'b0001, 4'b1010); end
                default: ;
            endcase
        end else begin
            if ($urandom_range(0, 7) == 0 || ((e % FRM) == FRM - 1 && $urandom_range(0, 1) == 1)) begin
                k = $urandom_range(0, 4);
                v = 16'($urandom);
                v = v & 16'(32'hFFFF >> (4 * k));
                doLoad(v, 4'($urandom), ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom));
            end
            if ($urandom_range(0, 63) == 0) mode_bcd = ~mode_bcd;
            if ($urandom_range(0, 31) == 0) brightness = 4'($urandom_range(0, 15));
        end
        @(posedge clk);
        #1;
        checkEdge();
        e++;
    endtask

    initial begin
        reset_n = 1'b0; load = 1'b0; value_in = '0; dp_in = '0; digit_en = '0;
        mode_bcd = 1'b0; brightness = 4'd15;
        #12;
        checkReset();
        @(negedge clk);
        reset_n = 1'b1;
        e = 0;

        for (int i = 0; i < 300; i++) runCycle(1'b1);
        for (int i = 0; i < 1500; i++) runCycle(1'b0);

        // Mid-scan asynchronous reset, then restart from digit 0 with empty display data
        load = 1'b0;
        #2 reset_n = 1'b0;
        #1 checkReset();
        @(negedge clk);
        reset_n = 1'b1;
        loadLog.delete();
        e = 0;
        brightness = 4'd15;
        for (int i = 0; i < 400; i++) runCycle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
- Parametrised multi-digit seven-segment scan controller for the Nexys4 display.
- Successor to the fixed 4-digit counter/anode driver: covers 1–8 digits, hex or BCD mode, leading-zero blanking, per-digit enable/decimal point and PWM brightness.
- Double-buffered value load, so the game score and power/angle readouts update tear-free at frame boundaries.
- Sits between the game logic and the An*/Ca..Cg/Dp pins in the top level.

Parameters:
- NUM_DIGITS, 8, number of scanned digits (1..8).
- SCAN_DIV, 100000, clk cycles per digit slot (1 ms at 100 MHz); minimum 2.
- PWM_W, 4, brightness resolution in bits.

Ports:
- clk  in  1  system clock (100 MHz).
- reset_n  in  1  asynchronous active-low reset.
- load  in  1  one-cycle strobe; captures value_in/dp_in/digit_en into the shadow register.
- value_in  in  4*NUM_DIGITS  nibble per digit; digit 0 in [3:0], rightmost.
- dp_in  in  NUM_DIGITS  decimal point request per digit, active high.
- digit_en  in  NUM_DIGITS  per-digit enable, active high.
- mode_bcd  in  1  0 = hex glyphs; 1 = BCD glyphs with leading-zero blanking.
- brightness  in  PWM_W  on-time duty; 0 = dark, 2^PWM_W-1 = full.
- load_ack  out  1  one-cycle pulse, the cycle after load is captured.
- frame_done  out  1  one-cycle pulse when the digit index wraps to 0.
- anode  out  NUM_DIGITS  active-low digit selects.
- ssdOut  out  7  active-low segments {Ca,Cb,Cc,Cd,Ce,Cf,Cg}.
- dp  out  1  active-low decimal point.

Behaviour:
- Reset state:
  - anode all 1s, ssdOut 7'h7F, dp 1, load_ack 0, frame_done 0.
  - Prescaler, digit index and PWM counter at 0.
  - Shadow and active registers: value 0, dp 0, digit_en 0.
  - pending flag 0.
- Reset mid-frame forces all outputs dark on the same asynchronous assertion.
- Prescaler:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - On wrap, the digit index increments modulo NUM_DIGITS.
- Frame boundary:
  - Occurs at the edge where the index goes NUM_DIGITS-1 -> 0.
  - frame_done is high for the following cycle.
  - If pending = 1, active <= shadow and pending <= 0 on that same edge.
- Load:
  - Shadow register captures the inputs and pending is set.
  - load_ack pulses the next cycle.
  - A load while pending overwrites the shadow (last wins).
  - A load on the frame-boundary edge: the active register takes the pre-edge shadow contents; the new data goes live at the following frame.
  - Worst-case load-to-display latency: NUM_DIGITS*SCAN_DIV + 1 cycles.
  - mode_bcd and brightness are live inputs, not buffered.
- PWM:
  - A free-running counter runs 0..2^PWM_W-2 and wraps.
  - The digit is "on" when pwm_cnt < brightness.
  - brightness 0 means never on; the maximum value means always on.
- Blanking: digit i is blanked if any of the following holds:
  - active digit_en[i] = 0;
  - PWM is off;
  - mode_bcd = 1, i > 0, and nibble i plus every higher-index nibble are all 0 (digit 0 is never zero-blanked).
- Output drive:
  - A blanked digit drives anode all 1s, ssdOut 7'h7F, dp 1.
  - An unblanked digit drives anode[idx] = 0 (all others 1).
  - dp = ~active dp[idx].
  - ssdOut = glyph(nibble).
- Glyphs:
  - Hex mode: standard 0–F (b, d lowercase).
  - BCD mode: nibble >9 shows "-" (ssdOut 7'b1111110).
- All outputs are registered: one-cycle latency from index/PWM state to pins. There are no combinational paths from inputs to outputs.

Decomposition:
- Package ssd_pkg:
  - 16-entry hex glyph constant table.
  - SEG_BLANK = 7'h7F, SEG_DASH = 7'b1111110.
  - Segment bit-order constants.
- Sub-module ssd_glyph_decoder: combinational, nibble + mode_bcd -> 7-bit active-low segments.
- Prescaler, index, PWM, buffering and blanking live in ssd_scan_ctrl.

Test Plan:
- NUM_DIGITS=4, SCAN_DIV=4, brightness=15, hex, load 16'h12AF, en=4'hF, after reset:
  - load_ack one cycle after load.
  - Next frame scans anode 1110/1101/1011/0111, 4 cycles each.
  - ssdOut sequence: F=0111000, A=0001000, 2=0010010, 1=1001111.
  - frame_done every 16 cycles.
- BCD, value 16'h0047:
  - Digits 0/1 show 7 and 4.
  - Digits 2/3 anode stay 1111 with ssdOut 7F.
  - Value 16'h0000 shows "0" on digit 0 only.
  - Value 16'h00C3 shows "3" and "-".
- Tear-free update:
  - load 16'h1111 mid-frame; digit outputs still show the old value until frame_done, then 1111.
  - Two loads in one frame: only the second appears.
  - load on the boundary edge: appears one frame later.
- Brightness 0: anode 1111 for a whole frame.
- Brightness 7 (PWM_W=4): each digit on exactly 7 of every 15 cycles, measured over 60 cycles.
- digit_en=4'b1010, dp_in=4'b0001: digits 0 and 2 dark; dp never 0, because digit 0 is disabled.
- Assert reset_n low mid-scan: outputs go to reset values immediately (asynchronous); after release, the scan restarts at digit 0 showing blank, since the active register is zero and disabled.
